// File: rtl/fault_pkg.sv
// Shared definitions for the fault-checking word path.
// - fsm_state_t : encoder sequencing states (IDLE, BURST, DONE)
// - LFSR_TAPS   : tap mask for x^8+x^6+x^5+x^4+1 (bit i = coefficient x^(i+1))
// - residue3()  : mod-3 check code, also used by the checker side
package fault_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } fsm_state_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [1:0] residue3(input logic [7:0] w);
    logic [7:0] r;
    r = w % 8'd3;
    return r[1:0];
  endfunction

endpackage

// File: rtl/fault_word_encoder_if.sv
// Host stream, injection control and checker-side word bus of the encoder.
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both high; the source holds its payload stable
// while valid is high and ready is low, and ready may depend on valid.
// - master : host/test side (drives stream input, injection, out_ready)
// - slave  : the encoder
interface fault_word_encoder_if;
  logic       mode;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       inj_en;
  logic       inj_chk;
  logic [2:0] inj_bit;
  logic [7:0] r0;
  logic [1:0] check;
  logic       out_valid;
  logic       out_ready;
  logic       fault_tag;
  logic       busy;
  logic       done;

  modport master (
    output mode, start, in_data, in_valid, inj_en, inj_chk, inj_bit, out_ready,
    input  in_ready, r0, check, out_valid, fault_tag, busy, done
  );

  modport slave (
    input  mode, start, in_data, in_valid, inj_en, inj_chk, inj_bit, out_ready,
    output in_ready, r0, check, out_valid, fault_tag, busy, done
  );
endinterface

// File: rtl/fault_word_encoder_lfsr8.sv
// 8-bit Fibonacci LFSR, shift left with feedback into bit 0.
// Ports:
//   clk, reset : clock, synchronous active-high reset (loads seed)
//   load       : synchronous reload of the seed
//   shift      : advance one step
//   q          : current LFSR value
module lfsr8
  import fault_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       shift,
  output logic [7:0] q
);

  // The all-zero state is a lock-up state, so a zero seed is replaced by 1.
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      q <= SEED_EFF;
    end else if (shift) begin
      q <= {q[6:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/fault_word_encoder.sv
// Produces operand r0 with its mod-3 check code for the fault checker, from
// either a host stream or an LFSR pattern burst, with optional injection of
// a data-bit or check-code fault on the word being loaded.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of fault_word_encoder_if (host stream, injection
//                controls, checker output word, busy/done status)
//   dbg_state  : current FSM state, for observation only
module fault_word_encoder
  import fault_pkg::*;
#(
  parameter int unsigned BURST_LEN = 16,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  fault_word_encoder_if.slave  bus,
  output fsm_state_t           dbg_state
);

  localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

  fsm_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] lfsr_q;
  logic       lfsr_load;

  logic [7:0] r0_q;
  logic [1:0] check_q;
  logic       out_valid_q;
  logic       fault_tag_q;
  logic       done_q, done_d;

  logic       load_ok;
  logic       host_take;
  logic       burst_take;
  logic       do_load;
  logic       drop_valid;
  logic [7:0] clean_word;
  logic [7:0] flip_mask;
  logic [7:0] ld_r0;
  logic [1:0] ld_check;

  // Output register may take a new word when empty or being drained now.
  assign load_ok = !out_valid_q || bus.out_ready;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .shift (burst_take),
    .q     (lfsr_q)
  );

  // Next-state and control
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    host_take  = 1'b0;
    burst_take = 1'b0;
    lfsr_load  = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.mode) begin
          // Host words are never accepted in pattern mode, even with start.
          if (bus.start) begin
            state_d   = BURST;
            lfsr_load = 1'b1;
            cnt_d     = 8'd0;
          end
        end else begin
          host_take = bus.in_valid && load_ok;
        end
      end
      BURST: begin
        if (load_ok) begin
          burst_take = 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      DONE: begin
        // Last burst word leaves the register this cycle.
        if (load_ok) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign do_load    = host_take || burst_take;
  assign drop_valid = load_ok && !do_load;

  // Injection: check code always comes from the clean word so a data-bit
  // flip shows up as a residue mismatch at the checker.
  assign clean_word = burst_take ? lfsr_q : bus.in_data;
  assign flip_mask  = 8'h01 << bus.inj_bit;
  assign ld_r0      = (bus.inj_en && !bus.inj_chk) ? (clean_word ^ flip_mask) : clean_word;
  assign ld_check   = residue3(clean_word) ^ ((bus.inj_en && bus.inj_chk) ? 2'b11 : 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r0_q        <= 8'd0;
      check_q     <= 2'd0;
      out_valid_q <= 1'b0;
      fault_tag_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= done_d;
      if (do_load) begin
        r0_q        <= ld_r0;
        check_q     <= ld_check;
        out_valid_q <= 1'b1;
        fault_tag_q <= bus.inj_en;
      end else if (drop_valid) begin
        out_valid_q <= 1'b0;
        fault_tag_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !bus.mode && load_ok;
  assign bus.r0        = r0_q;
  assign bus.check     = check_q;
  assign bus.out_valid = out_valid_q;
  assign bus.fault_tag = fault_tag_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign dbg_state     = state_q;

endmodule
